// File: rtl/bin_to_bcd_seq.sv
// Multi-channel sequential binary-to-BCD converter (double-dabble).
// All channels share one FSM and iteration counter; results appear with a one-cycle done pulse.
module bin_to_bcd_seq #(
   parameter int DATA_W   = 6,
   parameter int DIGITS   = 2,
   parameter int CHANNELS = 3,
   parameter int BLANK_LZ = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [CHANNELS*DATA_W-1:0]     bin_in,
   output logic                           busy,
   output logic                           done,
   output logic [CHANNELS*DIGITS*4-1:0]   bcd_out,
   output logic [CHANNELS-1:0]            ovf
);

   localparam int ACC_W = (DIGITS + 1) * 4;
   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   // Handshake: start is sampled only while IDLE; busy is high for exactly the DATA_W
   // shift cycles; done pulses for one cycle when the registered result becomes visible.
   logic [0:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic                    finish;
   logic [DATA_W-1:0]       sr      [CHANNELS];
   logic [ACC_W-1:0]        acc     [CHANNELS];
   logic [ACC_W-1:0]        acc_adj [CHANNELS];
   logic [CHANNELS-1:0]     sticky;
   logic [CHANNELS*DIGITS*4-1:0] res_bcd;
   logic [CHANNELS-1:0]     res_ovf;

   assign busy = (state == S_SHIFT);

   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         acc_adj[c] = acc[c];
         for (int n = 0; n <= DIGITS; n++) begin
            if (acc[c][n*4 +: 4] > 4'd4)
               acc_adj[c][n*4 +: 4] = acc[c][n*4 +: 4] + 4'd3;
         end
      end
   end

   // Overflow forces '-' on every digit; otherwise optional leading-zero blanking,
   // which stops at the first nonzero digit and never touches the units digit.
   always_comb begin : result_form
      logic lead;
      res_bcd = '0;
      res_ovf = '0;
      lead    = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         res_ovf[c] = (|acc[c][ACC_W-1 -: 4]) | sticky[c];
         lead       = (BLANK_LZ != 0);
         for (int d = DIGITS - 1; d >= 0; d--) begin
            if (res_ovf[c]) begin
               res_bcd[(c*DIGITS+d)*4 +: 4] = 4'd11;
            end else if (lead && (d != 0) && (acc[c][d*4 +: 4] == 4'd0)) begin
               res_bcd[(c*DIGITS+d)*4 +: 4] = 4'd10;
            end else begin
               res_bcd[(c*DIGITS+d)*4 +: 4] = acc[c][d*4 +: 4];
               lead = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         finish  <= 1'b0;
         done    <= 1'b0;
         sticky  <= '0;
         ovf     <= '0;
         bcd_out <= {(CHANNELS*DIGITS){4'd10}};
         for (int c = 0; c < CHANNELS; c++) begin
            sr[c]  <= '0;
            acc[c] <= '0;
         end
      end else begin
         done   <= 1'b0;
         finish <= 1'b0;
         // Result registration overlaps the IDLE cycle, so a new capture can share this edge.
         if (finish) begin
            bcd_out <= res_bcd;
            ovf     <= res_ovf;
            done    <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     sr[c]  <= bin_in[c*DATA_W +: DATA_W];
                     acc[c] <= '0;
                  end
                  sticky <= '0;
                  cnt    <= '0;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  acc[c]    <= {acc_adj[c][ACC_W-2:0], sr[c][DATA_W-1]};
                  sticky[c] <= sticky[c] | acc_adj[c][ACC_W-1];
                  sr[c]     <= sr[c] << 1;
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= S_IDLE;
                  finish <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default, blanking and overflow configurations against
// an arithmetic (divide/modulo) reference model.
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [17:0] bin_in;
   logic        busy, done;
   logic [23:0] bcd_out;
   logic [2:0]  ovf;

   logic        blk_start;
   logic [9:0]  blk_bin;
   logic        blk_busy, blk_done;
   logic [11:0] blk_bcd;
   logic [0:0]  blk_ovf;

   logic        o_start;
   logic [7:0]  o_bin;
   logic        o_busy, o_done;
   logic [7:0]  o_bcd;
   logic [0:0]  o_ovf;

   int vectors;
   int miscompares;
   logic [23:0] exp_q[$];

   bin_to_bcd_seq #(.DATA_W(6), .DIGITS(2), .CHANNELS(3), .BLANK_LZ(0)) dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf));

   bin_to_bcd_seq #(.DATA_W(10), .DIGITS(3), .CHANNELS(1), .BLANK_LZ(1)) u_blk (
      .clk(clk), .rst(rst), .start(blk_start), .bin_in(blk_bin),
      .busy(blk_busy), .done(blk_done), .bcd_out(blk_bcd), .ovf(blk_ovf));

   bin_to_bcd_seq #(.DATA_W(8), .DIGITS(2), .CHANNELS(1), .BLANK_LZ(0)) u_ovf (
      .clk(clk), .rst(rst), .start(o_start), .bin_in(o_bin),
      .busy(o_busy), .done(o_done), .bcd_out(o_bcd), .ovf(o_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Display codes for value v: decimal digits, 11 on overflow, 10 for blanked leading zeros.
   function automatic logic [43:0] ref_code(input longint v, input int ndig, input int blank);
      logic [43:0] r;
      longint p;
      longint lim;
      r   = '0;
      lim = 1;
      for (int i = 0; i < ndig; i++) lim = lim * 10;
      p = 1;
      for (int d = 0; d < ndig; d++) begin
         if (v >= lim)                      r[d*4 +: 4] = 4'd11;
         else if (blank != 0 && d > 0 && v < p) r[d*4 +: 4] = 4'd10;
         else                               r[d*4 +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [23:0] model_main(input logic [17:0] b);
      logic [23:0] r;
      logic [43:0] t;
      for (int c = 0; c < 3; c++) begin
         t = ref_code(longint'(b[c*6 +: 6]), 2, 0);
         r[c*8 +: 8] = t[7:0];
      end
      return r;
   endfunction

   function automatic logic dut_done(input int which);
      case (which)
         0: return done;
         1: return blk_done;
         default: return o_done;
      endcase
   endfunction

   function automatic logic dut_busy(input int which);
      case (which)
         0: return busy;
         1: return blk_busy;
         default: return o_busy;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic convert(input int which, input logic [17:0] b);
      int lat;
      int busy_n;
      int dw;
      logic [43:0] t;
      dw = (which == 0) ? 6 : (which == 1) ? 10 : 8;
      @(posedge clk); #1;
      case (which)
         0: begin bin_in = b; start = 1'b1; end
         1: begin blk_bin = b[9:0]; blk_start = 1'b1; end
         default: begin o_bin = b[7:0]; o_start = 1'b1; end
      endcase
      @(posedge clk); #1;
      start = 1'b0; blk_start = 1'b0; o_start = 1'b0;
      lat = 0;
      busy_n = 0;
      @(negedge clk);
      if (dut_busy(which)) busy_n++;
      while (!dut_done(which) && lat < 100) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (dut_busy(which)) busy_n++;
      end
      check("latency", lat, dw + 1);
      check("busy_cycles", busy_n, dw);
      case (which)
         0: begin
            check("main_bcd", bcd_out, model_main(b));
            check("main_ovf", ovf, 3'b000);
         end
         1: begin
            t = ref_code(longint'(b[9:0]), 3, 1);
            check("blk_bcd", blk_bcd, t[11:0]);
            check("blk_ovf", blk_ovf, b[9:0] > 10'd999);
         end
         default: begin
            t = ref_code(longint'(b[7:0]), 2, 0);
            check("ovf_bcd", o_bcd, t[7:0]);
            check("ovf_ovf", o_ovf, b[7:0] > 8'd99);
         end
      endcase
      @(negedge clk);
      check("done_one_cycle", dut_done(which), 1'b0);
   endtask

   initial begin
      logic [17:0] a;
      logic [17:0] b;
      logic [23:0] prev;
      int k;
      int dones;
      vectors     = 0;
      miscompares = 0;
      rst = 1'b0; start = 1'b0; bin_in = '0;
      blk_start = 1'b0; blk_bin = '0; o_start = 1'b0; o_bin = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_bcd", bcd_out, 24'hAAAAAA);
      check("reset_ovf", ovf, 3'b000);
      check("reset_blk_bcd", blk_bcd, 12'hAAA);
      @(posedge clk); #1 rst = 1'b1;

      // Directed default-configuration vectors.
      convert(0, {6'd23, 6'd59, 6'd7});
      check("spec_vector", bcd_out, 24'h235907);
      convert(0, {6'd0, 6'd0, 6'd56});
      check("ch0_56", bcd_out[7:0], 8'h56);
      convert(0, {6'd63, 6'd10, 6'd0});
      check("ch0_zero_unblanked", bcd_out[7:0], 8'h00);
      for (int i = 0; i < 6; i++) convert(0, 18'($urandom));

      // Outputs hold across IDLE.
      prev = bcd_out;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("hold_idle", bcd_out, prev);

      // Start while busy is ignored; bin_in changes after capture have no effect.
      a = 18'($urandom);
      @(posedge clk); #1 bin_in = a; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 bin_in = ~a; start = 1'b1;
      @(negedge clk);
      check("hold_shift", bcd_out, prev);
      @(posedge clk); #1 start = 1'b0;
      k = 3;
      @(negedge clk);
      while (!done && k < 100) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check("midconv_latency", k, 7);
      check("midconv_bcd", bcd_out, model_main(a));
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("busy_start_not_queued", dones, 0);

      // Start held high: back-to-back conversions, one done every 7 cycles.
      exp_q.delete();
      dones = 0;
      for (int j = 0; j < 25; j++) begin
         if (j < 20) begin
            b = 18'($urandom);
            bin_in = b;
            start = 1'b1;
            if (j % 7 == 0) exp_q.push_back(model_main(b));
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            dones++;
            check("b2b_spacing", j % 7, 0);
            check("b2b_queue", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check("b2b_bcd", bcd_out, exp_q.pop_front());
         end
      end
      start = 1'b0;
      check("b2b_count", dones, 3);
      check("b2b_drained", exp_q.size(), 0);

      // Blanking configuration.
      convert(1, 18'd7);
      check("blk_7", blk_bcd, 12'hAA7);
      convert(1, 18'd0);
      check("blk_0", blk_bcd, 12'hAA0);
      convert(1, 18'd105);
      check("blk_105", blk_bcd, 12'h105);
      for (int i = 0; i < 6; i++) convert(1, 18'($urandom_range(0, 1023)));

      // Overflow configuration.
      convert(2, 18'd99);
      check("ovf_99", o_bcd, 8'h99);
      convert(2, 18'd100);
      check("ovf_100", {o_ovf, o_bcd}, 9'h1BB);
      convert(2, 18'd255);
      check("ovf_255", {o_ovf, o_bcd}, 9'h1BB);
      for (int i = 0; i < 6; i++) convert(2, 18'($urandom_range(0, 255)));

      // Reset during SHIFT aborts the conversion.
      @(posedge clk); #1 bin_in = 18'($urandom); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_bcd", bcd_out, 24'hAAAAAA);
      check("abort_ovf", ovf, 3'b000);
      @(posedge clk); #1 rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("abort_no_done", dones, 0);
      convert(0, 18'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
